// File: rtl/rx_axis_pkg.sv
// Shared definitions for the rx AXIS packet reader.
//   WIDTH/KEEP/LEN_W : beat width, bytes per beat, length field width
//   OBUF_DEPTH       : output buffer entries (read-ahead limit)
//   rd_state_e       : reader FSM states
//   beat_t           : one buffered output beat {data, keep, last}
package rx_axis_pkg;

  localparam int unsigned WIDTH      = 256;
  localparam int unsigned KEEP       = WIDTH / 8;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned OBUF_DEPTH = 3;
  localparam int unsigned KEEP_LOG2  = $clog2(KEEP);
  // 65535 bytes needs 2048 words, which fits LEN_W-4 bits
  localparam int unsigned WCNT_W     = LEN_W - 4;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    DATA
  } rd_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [KEEP-1:0]  keep;
    logic             last;
  } beat_t;

  // Number of data words spanned by a packet of len bytes (ceiling division).
  function automatic logic [WCNT_W-1:0] words_for_len(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(KEEP - 1);
    return WCNT_W'(sum >> KEEP_LOG2);
  endfunction

  // Byte enables of the final beat of a packet of len bytes.
  function automatic logic [KEEP-1:0] keep_for_len(input logic [LEN_W-1:0] len);
    logic [KEEP_LOG2-1:0] rem;
    rem = len[KEEP_LOG2-1:0];
    if (rem == '0) begin
      return '1;
    end
    return (KEEP'(1) << rem) - KEEP'(1);
  endfunction

endpackage

// File: rtl/rx_axis_obuf.sv
// 3-entry synchronous FIFO of output beats.
//   clk, reset_ : clock, asynchronous active-low reset
//   push, push_beat : write request and the beat to store
//   pop         : remove the head entry (ignored when empty)
//   occ         : current number of stored beats
//   head        : oldest stored beat (storage is cleared on reset)
module rx_axis_obuf
  import rx_axis_pkg::*;
(
  input  logic       clk,
  input  logic       reset_,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output logic [1:0] occ,
  output beat_t      head
);

  beat_t      mem [OBUF_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(OBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'(OBUF_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/rx_axis_pkt_reader.sv
// Drains the rx data FIFO and packet-length FIFO and presents each packet
// as an AXI4-Stream master with byte-accurate tkeep/tlast.
//   clk, reset_            : FIFO read clock, asynchronous active-low reset
//   ctl_rdempty/rden/dataout : length FIFO read side (data valid cycle after rden)
//   dat_rdempty/rden/dataout : data FIFO read side (data valid cycle after rden)
//   m_axis_*               : AXI4-Stream master output
//   pkt_cnt                : packets delivered (tlast handshakes), wraps
//   err_zero_len           : sticky, a zero-length entry was popped
module rx_axis_pkt_reader
  import rx_axis_pkg::*;
(
  input  logic             clk,
  input  logic             reset_,
  input  logic             ctl_rdempty,
  output logic             ctl_rden,
  input  logic [LEN_W-1:0] ctl_dataout,
  input  logic             dat_rdempty,
  output logic             dat_rden,
  input  logic [WIDTH-1:0] dat_dataout,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [KEEP-1:0]  m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic [31:0]      pkt_cnt,
  output logic             err_zero_len
);

  rd_state_e         state, state_nxt;
  logic [WCNT_W-1:0] words_left, words_left_nxt;
  logic [KEEP-1:0]   last_keep, last_keep_nxt;
  logic              zero_len_hit;
  logic              rd_last;
  logic [KEEP-1:0]   rd_keep;

  logic              inflight;
  logic              tag_last;
  logic [KEEP-1:0]   tag_keep;
  logic [1:0]        occ;
  logic              credit_ok;
  logic              pop;
  beat_t             push_beat;
  beat_t             head;

  // Read-ahead credit uses only registered terms so tready never reaches a
  // FIFO read enable combinationally.
  assign credit_ok = ({1'b0, occ} + {2'b0, inflight}) < 3'(OBUF_DEPTH);

  always_comb begin
    state_nxt      = state;
    words_left_nxt = words_left;
    last_keep_nxt  = last_keep;
    ctl_rden       = 1'b0;
    dat_rden       = 1'b0;
    zero_len_hit   = 1'b0;
    rd_last        = 1'b0;
    rd_keep        = '1;
    case (state)
      IDLE: begin
        if (!ctl_rdempty) begin
          ctl_rden  = 1'b1;
          state_nxt = LEN;
        end
      end
      LEN: begin
        if (ctl_dataout == '0) begin
          zero_len_hit = 1'b1;
          state_nxt    = IDLE;
        end else begin
          words_left_nxt = words_for_len(ctl_dataout);
          last_keep_nxt  = keep_for_len(ctl_dataout);
          state_nxt      = DATA;
        end
      end
      DATA: begin
        if (!dat_rdempty && credit_ok) begin
          dat_rden       = 1'b1;
          words_left_nxt = words_left - WCNT_W'(1);
          if (words_left == WCNT_W'(1)) begin
            rd_last   = 1'b1;
            rd_keep   = last_keep;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state        <= IDLE;
      words_left   <= '0;
      last_keep    <= '0;
      inflight     <= 1'b0;
      tag_last     <= 1'b0;
      tag_keep     <= '0;
      err_zero_len <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      state      <= state_nxt;
      words_left <= words_left_nxt;
      last_keep  <= last_keep_nxt;
      inflight   <= dat_rden;
      tag_last   <= rd_last;
      tag_keep   <= rd_keep;
      if (zero_len_hit) begin
        err_zero_len <= 1'b1;
      end
      if (pop && m_axis_tlast) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end

  assign push_beat = '{data: dat_dataout, keep: tag_keep, last: tag_last};
  assign pop       = m_axis_tvalid && m_axis_tready;

  rx_axis_obuf u_obuf (
    .clk       (clk),
    .reset_    (reset_),
    .push      (inflight),
    .push_beat (push_beat),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = head.data;
  assign m_axis_tkeep  = head.keep;
  assign m_axis_tlast  = head.last;

endmodule

// File: tb/tb_rx_axis_pkt_reader.sv
// Self-checking bench for rx_axis_pkt_reader: models both FIFOs, a
// packet-level expected beat queue, and checks every output cycle.
module tb_rx_axis_pkt_reader;

  logic         clk = 1'b0;
  logic         reset_ = 1'b0;
  logic         ctl_rdempty = 1'b1;
  logic         ctl_rden;
  logic [15:0]  ctl_dataout = '0;
  logic         dat_rdempty = 1'b1;
  logic         dat_rden;
  logic [255:0] dat_dataout = '0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [31:0]  pkt_cnt;
  logic         err_zero_len;

  always #5 clk = ~clk;

  rx_axis_pkt_reader dut (
    .clk           (clk),
    .reset_        (reset_),
    .ctl_rdempty   (ctl_rdempty),
    .ctl_rden      (ctl_rden),
    .ctl_dataout   (ctl_dataout),
    .dat_rdempty   (dat_rdempty),
    .dat_rden      (dat_rden),
    .dat_dataout   (dat_dataout),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_cnt       (pkt_cnt),
    .err_zero_len  (err_zero_len)
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } exp_beat_t;

  int checks = 0;
  int errors = 0;

  logic [255:0] dat_q[$];
  logic [255:0] dat_pend[$];
  logic [15:0]  ctl_q[$];
  exp_beat_t    exp_q[$];
  int           rd_cyc_q[$];

  int           cyc = 0;
  int           ctl_rd_cyc = 0;
  int           first_dat_cyc = -1;
  int           first_valid_cyc = -1;
  int unsigned  rd_pulses = 0;
  int unsigned  beats_seen = 0;
  int unsigned  pkt_beat_ctr = 0;
  int unsigned  last_pkt_beats = 0;
  logic [31:0]  last_keep_seen = '0;
  logic [31:0]  exp_pkt_cnt = '0;
  bit           zero_popped = 0;
  bit           release_all = 1;
  bit           log_rd = 0;
  int unsigned  tready_pct = 100;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte b of beat i is enabled exactly when that byte lies inside the packet.
  function automatic logic [31:0] model_keep(input int unsigned len, input int unsigned beat);
    logic [31:0] k;
    k = '0;
    for (int b = 0; b < 32; b++) begin
      if (beat * 32 + b < len) k[b] = 1'b1;
    end
    return k;
  endfunction

  task automatic send_pkt(input int unsigned len, input bit preload);
    int unsigned nw;
    logic [255:0] d;
    exp_beat_t e;
    nw = (len + 31) / 32;
    for (int unsigned i = 0; i < nw; i++) begin
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      if (preload) dat_q.push_back(d);
      else dat_pend.push_back(d);
      e.data = d;
      e.keep = model_keep(len, i);
      e.last = (i == nw - 1);
      exp_q.push_back(e);
    end
    ctl_q.push_back(16'(len));
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && ctl_q.size() == 0 && dat_q.size() == 0 &&
          dat_pend.size() == 0 && !m_axis_tvalid) done = 1;
    end
    chk("drain_done", done, 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Data / length FIFO models: rdempty reflects the queues, dataout updates
  // the cycle after a read strobe.
  initial begin : fifo_model
    bit rd_c, rd_d;
    int n;
    forever begin
      @(negedge clk);
      rd_c = ctl_rden;
      rd_d = dat_rden;
      if (reset_) begin
        if (rd_c) begin
          chk("ctl_rd_when_empty", ctl_rdempty, 0);
          ctl_rd_cyc = cyc;
        end
        if (rd_d) begin
          chk("dat_rd_when_empty", dat_rdempty, 0);
          rd_pulses++;
          if (first_dat_cyc < 0) first_dat_cyc = cyc;
          if (log_rd) rd_cyc_q.push_back(cyc);
        end
      end
      @(posedge clk); #1;
      if (reset_) begin
        if (rd_c && ctl_q.size() > 0) begin
          ctl_dataout = ctl_q.pop_front();
          if (ctl_dataout == 16'd0) zero_popped = 1;
        end
        if (rd_d && dat_q.size() > 0) dat_dataout = dat_q.pop_front();
      end
      n = release_all ? dat_pend.size() : int'($urandom_range(0, 2));
      while (n > 0 && dat_pend.size() > 0) begin
        dat_q.push_back(dat_pend.pop_front());
        n--;
      end
      ctl_rdempty   = (ctl_q.size() == 0);
      dat_rdempty   = (dat_q.size() == 0);
      m_axis_tready = ($urandom_range(0, 99) < tready_pct);
    end
  end

  // Output checker against the expected beat queue.
  initial begin : compare
    bit           stall_prev;
    logic [255:0] p_data;
    logic [31:0]  p_keep;
    logic         p_last;
    exp_beat_t    e;
    stall_prev = 0;
    p_data = '0;
    p_keep = '0;
    p_last = 0;
    forever begin
      @(negedge clk);
      if (!reset_) begin
        stall_prev = 0;
      end else begin
        chk("pkt_cnt", pkt_cnt, exp_pkt_cnt);
        chk("err_without_zero_len", err_zero_len & ~zero_popped, 0);
        if (stall_prev) begin
          chk("hold_tvalid", m_axis_tvalid, 1);
          chk("hold_tdata", m_axis_tdata, p_data);
          chk("hold_tkeep", m_axis_tkeep, p_keep);
          chk("hold_tlast", m_axis_tlast, p_last);
        end
        if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", m_axis_tdata, e.data);
            chk("tkeep", m_axis_tkeep, e.keep);
            chk("tlast", m_axis_tlast, e.last);
            beats_seen++;
            pkt_beat_ctr++;
            if (e.last) begin
              exp_pkt_cnt++;
              last_keep_seen = m_axis_tkeep;
              last_pkt_beats = pkt_beat_ctr;
              pkt_beat_ctr   = 0;
            end
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        p_data = m_axis_tdata;
        p_keep = m_axis_tkeep;
        p_last = m_axis_tlast;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned len;
    int unsigned base;
    bit          reached;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err", err_zero_len, 0);
    chk("rst_dat_rden", dat_rden, 0);
    reset_ = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // 64 bytes: two full beats, latency from length read
    first_dat_cyc = -1;
    first_valid_cyc = -1;
    send_pkt(64, 1);
    wait_idle(100);
    chk("lat_first_rden", 256'(first_dat_cyc - ctl_rd_cyc), 2);
    chk("lat_first_tvalid", 256'(first_valid_cyc - ctl_rd_cyc), 4);
    chk("len64_beats", last_pkt_beats, 2);
    chk("len64_keep", last_keep_seen, 32'hFFFF_FFFF);
    chk("len64_pkt_cnt", pkt_cnt, 1);

    // 33 bytes and 1 byte: partial final beats
    send_pkt(33, 1);
    wait_idle(100);
    chk("len33_beats", last_pkt_beats, 2);
    chk("len33_keep", last_keep_seen, 32'h0000_0001);
    send_pkt(1, 1);
    wait_idle(100);
    chk("len1_beats", last_pkt_beats, 1);
    chk("len1_keep", last_keep_seen, 32'h0000_0001);
    chk("len1_pkt_cnt", pkt_cnt, 3);

    // Back-to-back single-beat packets: reads spaced by 3 cycles
    rd_cyc_q.delete();
    log_rd = 1;
    for (int i = 0; i < 3; i++) send_pkt(32, 1);
    wait_idle(100);
    log_rd = 0;
    chk("b2b_reads", rd_cyc_q.size(), 3);
    if (rd_cyc_q.size() == 3) begin
      chk("b2b_gap1", 256'(rd_cyc_q[1] - rd_cyc_q[0]), 3);
      chk("b2b_gap2", 256'(rd_cyc_q[2] - rd_cyc_q[1]), 3);
    end
    chk("b2b_pkt_cnt", pkt_cnt, 6);

    // Back-pressure: read-ahead limited to the buffer depth
    tready_pct = 0;
    rd_pulses = 0;
    send_pkt(320, 1);
    repeat (20) @(posedge clk);
    #2;
    chk("stall_reads", rd_pulses, 3);
    chk("stall_tvalid", m_axis_tvalid, 1);
    tready_pct = 100;
    wait_idle(200);
    chk("len320_beats", last_pkt_beats, 10);
    chk("len320_pkt_cnt", pkt_cnt, 7);

    // Zero-length entry then a real packet
    rd_pulses = 0;
    send_pkt(0, 1);
    send_pkt(32, 1);
    wait_idle(100);
    chk("zero_err", err_zero_len, 1);
    chk("zero_reads", rd_pulses, 1);
    chk("zero_next_beats", last_pkt_beats, 1);
    chk("zero_pkt_cnt", pkt_cnt, 8);

    // Maximum length: word counter boundary
    send_pkt(65535, 1);
    wait_idle(5000);
    chk("max_beats", last_pkt_beats, 2048);
    chk("max_keep", last_keep_seen, 32'h7FFF_FFFF);

    // Randomized traffic: trickled data, random back-pressure
    release_all = 0;
    tready_pct = 70;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       len = 0;
        1, 2:    len = $urandom_range(1, 8) * 32;
        default: len = $urandom_range(1, 300);
      endcase
      send_pkt(len, 0);
    end
    wait_idle(30000);
    release_all = 1;
    tready_pct = 100;

    // Reset in the middle of a 4-beat packet
    base = beats_seen;
    send_pkt(128, 1);
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk); #1;
      if (beats_seen - base >= 2) reached = 1;
    end
    chk("mid_reset_reach", reached, 1);
    reset_ = 1'b0;
    #1;
    chk("mrst_tvalid", m_axis_tvalid, 0);
    chk("mrst_tdata", m_axis_tdata, 0);
    chk("mrst_tkeep", m_axis_tkeep, 0);
    chk("mrst_tlast", m_axis_tlast, 0);
    chk("mrst_pkt_cnt", pkt_cnt, 0);
    chk("mrst_err", err_zero_len, 0);
    chk("mrst_dat_rden", dat_rden, 0);
    exp_q.delete();
    dat_q.delete();
    dat_pend.delete();
    ctl_q.delete();
    exp_pkt_cnt = '0;
    pkt_beat_ctr = 0;
    zero_popped = 0;
    repeat (3) @(posedge clk);
    #2;
    reset_ = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    send_pkt(40, 1);
    wait_idle(100);
    chk("post_rst_beats", last_pkt_beats, 2);
    chk("post_rst_keep", last_keep_seen, 32'h0000_00FF);
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    chk("post_rst_err", err_zero_len, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_axis_pkt_reader.md
# rx_axis_pkt_reader

Drains the receive data FIFO (1024 x 256-bit, read side) and its companion packet-length FIFO, and presents each received packet as an AXI4-Stream master with byte-accurate tkeep and tlast. Sits directly downstream of the rx data FIFO in the AXIS bridge, on the FIFO read clock domain. Absorbs sink back-pressure through a 3-entry output buffer, so no combinational path runs from m_axis_tready to any FIFO read enable.

## Interface
- WIDTH, 256, data beat width in bits (multiple of 8)
- KEEP, 32, bytes per beat (WIDTH/8)
- LEN_W, 16, packet length field width in bytes
- clk  in  1  read-side clock (same clock as the data FIFO rdclk)
- reset_  in  1  asynchronous, active-low reset
- ctl_rdempty  in  1  length FIFO empty
- ctl_rden  out  1  length FIFO read strobe
- ctl_dataout  in  LEN_W  packet length in bytes, valid the cycle after ctl_rden
- dat_rdempty  in  1  data FIFO empty
- dat_rden  out  1  data FIFO read strobe
- dat_dataout  in  WIDTH  data word, valid the cycle after dat_rden; byte 0 in [7:0]
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tdata  out  WIDTH  beat data
- m_axis_tkeep  out  KEEP  byte enables, LSB = byte 0
- m_axis_tlast  out  1  last beat of packet
- pkt_cnt  out  32  packets delivered (increments on tlast handshake, wraps)
- err_zero_len  out  1  sticky: a zero-length entry was popped

## Operation
- Words per packet: nw = (len + KEEP-1) >> log2(KEEP); counter is LEN_W-4 bits (max 2048 for 65535 bytes).
- Last-beat keep: len mod KEEP == 0 → all ones; else (1 << (len mod KEEP)) - 1. Non-last beats: all ones.
- FSM states:
  - IDLE: if !ctl_rdempty, assert ctl_rden for one cycle → LEN.
  - LEN: capture ctl_dataout. len == 0 → set err_zero_len, drop the entry, → IDLE. Otherwise load words_left = nw and last_keep → DATA.
  - DATA: assert dat_rden when !dat_rdempty and credit is available; decrement words_left on each read. The read issuing the final word → IDLE.
- Credit rule: dat_rden is allowed only when occ + inflight < 3. occ is the output buffer occupancy and inflight (0/1) is the read issued last cycle. Both terms are registered; tready does not enter the equation.
- Each issued read carries a {last, keep} tag through a 1-cycle pipeline register. The tag is written into the buffer together with dat_dataout.
- Output buffer pops on m_axis_tvalid && m_axis_tready. Once tvalid is high, tdata/tkeep/tlast stay stable until the handshake.
- Simultaneous push and pop in one cycle: occ unchanged, ordering preserved.
- Never reads a FIFO while its rdempty is high. Never reads data beyond nw for the current packet.

## Timing
- Reset (async assert, sync release): FSM = IDLE; ctl_rden = dat_rden = 0; m_axis_tvalid = 0; tdata = 0, tkeep = 0, tlast = 0; pkt_cnt = 0; err_zero_len = 0; buffer empty; inflight = 0.
- Reset mid-packet: partial packet is discarded with no tlast emitted. FIFO contents are not flushed by this block.
- Latency: ctl_rden at cycle T, first dat_rden at T+2, first tvalid at T+4 at the earliest.
- Throughput: 1 beat/cycle while tready = 1 and the data FIFO is non-empty.
- Inter-packet gap: 2 idle issue cycles (IDLE, LEN) after the final read of each packet.
- tready held low: at most 3 words are read ahead, then dat_rden stays 0.

## Structure
- Shared package rx_axis_pkg:
  - constants WIDTH, KEEP, LEN_W, OBUF_DEPTH = 3
  - FSM state enum {IDLE, LEN, DATA}
  - beat struct {data, keep, last}
- Sub-module rx_axis_obuf: 3-entry synchronous FIFO of the beat struct, exposing occ, push, pop and head outputs.

## Test plan
- len = 64, tready = 1: exactly 2 beats; keep = 0xFFFFFFFF on both; tlast on beat 2; pkt_cnt 0→1; first tvalid at T+4.
- len = 33: 2 beats; beat 2 keep = 0x00000001 with tlast; len = 1: 1 beat, keep = 0x1, tlast = 1.
- Three back-to-back 32-byte packets, tready = 1: 3 single-beat packets; each new dat_rden exactly 3 cycles after the previous one; pkt_cnt = 3.
- len = 320 with tready = 0 for 20 cycles, then 1: only 3 dat_rden pulses while stalled; all 10 beats delivered in order with data intact.
- Length entry 0 followed by len = 32: err_zero_len = 1; no data read for the zero entry; next packet emits 1 beat with tlast.
- reset_ pulsed low after 2 of 4 beats: all outputs return to reset values immediately; a fresh length entry after release produces a correct packet.
